// File: rtl/rx_dfe_pkg.sv
// Shared types and defaults for the receive DFE slice.
// The sample format matches the channel-filter output so rx_dfe can follow it directly.
package rx_dfe_pkg;

  localparam int RX_N_TAPS         = 4;
  localparam int RX_SAMPLE_WIDTH   = 16;
  localparam int RX_TAP_WIDTH      = 12;
  localparam int RX_TAP_ADDR_WIDTH = (RX_N_TAPS > 1) ? $clog2(RX_N_TAPS) : 1;

  typedef logic signed [RX_SAMPLE_WIDTH-1:0] RX_SAMPLE_FORMAT;
  typedef logic signed [RX_TAP_WIDTH-1:0]    RX_TAP_FORMAT;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

  // Headroom for the input sample plus the sum of all tap contributions and its negation.
  function automatic int rx_acc_width(input int sample_w, input int n_taps);
    return sample_w + $clog2(n_taps) + 2;
  endfunction

endpackage

// File: rtl/dfe_tap_sum.sv
// Combinational DFE feedback: signed sum of +/- tap weights selected by past decisions.
// Taps at or beyond the fill count contribute nothing, so a fresh history is not trusted.
module dfe_tap_sum
  import rx_dfe_pkg::*;
#(
  parameter int N_TAPS     = RX_N_TAPS,
  parameter int TAP_WIDTH  = RX_TAP_WIDTH,
  parameter int FILL_WIDTH = $clog2(RX_N_TAPS + 1),
  parameter int ACC_WIDTH  = rx_acc_width(RX_SAMPLE_WIDTH, RX_N_TAPS)
) (
  input  logic [N_TAPS-1:0]                hist_i,
  input  logic [N_TAPS-1:0][TAP_WIDTH-1:0] taps_i,
  input  logic [FILL_WIDTH-1:0]            fill_i,
  output logic signed [ACC_WIDTH-1:0]      fb_o
);

  logic signed [ACC_WIDTH-1:0] acc_s;
  logic signed [ACC_WIDTH-1:0] term_s;

  always_comb begin
    acc_s  = '0;
    term_s = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      term_s = ACC_WIDTH'($signed(taps_i[i]));
      if (FILL_WIDTH'(i) < fill_i) begin
        if (hist_i[i]) begin
          acc_s = acc_s + term_s;
        end else begin
          acc_s = acc_s - term_s;
        end
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign fb_o = acc_s;

endmodule

// File: rtl/rx_dfe.sv
// Receive decision-feedback equalizer: subtracts weighted past decisions, saturates and slices.
// Outputs are registered one cycle after the accepted sample; taps are runtime-writable.
module rx_dfe
  import rx_dfe_pkg::*;
#(
  parameter int N_TAPS         = RX_N_TAPS,
  parameter int SAMPLE_WIDTH   = RX_SAMPLE_WIDTH,
  parameter int TAP_WIDTH      = RX_TAP_WIDTH,
  parameter int TAP_ADDR_WIDTH = RX_TAP_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] in_i,
  input  logic                           in_valid_i,
  input  logic                           tap_wr_en_i,
  input  logic [TAP_ADDR_WIDTH-1:0]      tap_addr_i,
  input  logic signed [TAP_WIDTH-1:0]    tap_data_i,
  output logic                           out_bit_o,
  output logic                           out_valid_o,
  output logic signed [SAMPLE_WIDTH-1:0] eq_out_o,
  output logic                           sat_flag_o,
  output logic                           locked_o
);

  localparam int FILL_WIDTH = $clog2(N_TAPS + 1);
  localparam int ACC_WIDTH  = rx_acc_width(SAMPLE_WIDTH, N_TAPS);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  rx_state_e                        state_q, state_d;
  logic [FILL_WIDTH-1:0]            fill_q, fill_d;
  logic [N_TAPS-1:0]                hist_q, hist_d;
  logic [N_TAPS-1:0][TAP_WIDTH-1:0] taps_q, taps_d;
  logic                             out_bit_q, out_bit_d;
  logic                             out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0]          eq_out_q, eq_out_d;
  logic                             sat_q, sat_d;
  logic                             locked_q, locked_d;

  logic signed [ACC_WIDTH-1:0]      fb_s;
  logic signed [ACC_WIDTH-1:0]      eq_s;
  logic                             dec_s;

  dfe_tap_sum #(
    .N_TAPS     (N_TAPS),
    .TAP_WIDTH  (TAP_WIDTH),
    .FILL_WIDTH (FILL_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_tap_sum (
    .hist_i (hist_q),
    .taps_i (taps_q),
    .fill_i (fill_q),
    .fb_o   (fb_s)
  );

  // The slicer works on the unsaturated value; the sign is the same after clipping.
  assign eq_s  = ACC_WIDTH'(in_i) - fb_s;
  assign dec_s = ~eq_s[ACC_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    hist_d      = hist_q;
    taps_d      = taps_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    eq_out_d    = eq_out_q;
    sat_d       = sat_q;

    // The sample path above reads taps_q, so a same-edge write is seen only by later samples.
    if (tap_wr_en_i && (int'(tap_addr_i) < N_TAPS)) begin
      taps_d[tap_addr_i] = tap_data_i;
    end else begin
      taps_d = taps_q;
    end

    if (in_valid_i) begin
      out_valid_d = 1'b1;
      out_bit_d   = dec_s;
      if (eq_s > SAT_MAX) begin
        eq_out_d = SAT_MAX[SAMPLE_WIDTH-1:0];
        sat_d    = 1'b1;
      end else if (eq_s < SAT_MIN) begin
        eq_out_d = SAT_MIN[SAMPLE_WIDTH-1:0];
        sat_d    = 1'b1;
      end else begin
        eq_out_d = eq_s[SAMPLE_WIDTH-1:0];
        sat_d    = 1'b0;
      end

      hist_d[0] = dec_s;
      for (int i = 1; i < N_TAPS; i++) begin
        hist_d[i] = hist_q[i-1];
      end

      case (state_q)
        ST_FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_d == FILL_WIDTH'(N_TAPS)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN: begin
          fill_d  = FILL_WIDTH'(N_TAPS);
          state_d = ST_RUN;
        end
        default: begin
          fill_d  = '0;
          state_d = ST_FILL;
        end
      endcase
    end else begin
      out_valid_d = 1'b0;
    end

    locked_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      hist_q      <= '0;
      taps_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      eq_out_q    <= '0;
      sat_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      hist_q      <= hist_d;
      taps_q      <= taps_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      eq_out_q    <= eq_out_d;
      sat_q       <= sat_d;
      locked_q    <= locked_d;
    end
  end

  assign out_bit_o   = out_bit_q;
  assign out_valid_o = out_valid_q;
  assign eq_out_o    = eq_out_q;
  assign sat_flag_o  = sat_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_rx_dfe.sv
// Directed bench for rx_dfe (4 taps, 16-bit samples, 12-bit taps) with hand-computed results.
module tb_rx_dfe;

  logic               clk;
  logic               rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               tap_wr_en;
  logic [1:0]         tap_addr;
  logic signed [11:0] tap_data;
  logic               out_bit;
  logic               out_valid;
  logic signed [15:0] eq_out;
  logic               sat_flag;
  logic               locked;

  int errors = 0;
  int checks = 0;

  rx_dfe dut (
    .clk         (clk),
    .rst         (rst),
    .in_i        (din),
    .in_valid_i  (din_valid),
    .tap_wr_en_i (tap_wr_en),
    .tap_addr_i  (tap_addr),
    .tap_data_i  (tap_data),
    .out_bit_o   (out_bit),
    .out_valid_o (out_valid),
    .eq_out_o    (eq_out),
    .sat_flag_o  (sat_flag),
    .locked_o    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int v);
    din       = 16'(v);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    tap_wr_en = 1'b1;
    tap_addr  = 2'(a);
    tap_data  = 12'(d);
    tick();
    tap_wr_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int b, input int e, input int s);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".bit"}, out_bit, b);
    chk({tag, ".eq"}, eq_out, e);
    chk({tag, ".sat"}, sat_flag, s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0;
    tap_wr_en = 1'b0; tap_addr = '0; tap_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state and zero-tap slicing
    chk("rst.locked", locked, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.eq", eq_out, 0);
    chk("rst.bit", out_bit, 0);
    chk("rst.sat", sat_flag, 0);
    sample(100);  chk_out("zt.p100", 1, 100, 0);
    sample(-1);   chk_out("zt.m1", 0, -1, 0);
    sample(0);    chk_out("zt.zero", 1, 0, 0);
    tick();
    chk("zt.idle.valid", out_valid, 0);
    chk("zt.idle.eq", eq_out, 0);
    chk("zt.idle.bit", out_bit, 1);
    chk("zt.locked", locked, 0);

    // 2: tap masking during fill
    do_reset();
    wr(0, 50);
    chk("mask.wr.valid", out_valid, 0);
    sample(100);  chk_out("mask.s1", 1, 100, 0);
    sample(30);   chk_out("mask.s2", 0, -20, 0);

    // 3: lock with idle gaps
    do_reset();
    sample(5);    chk_out("lock.s1", 1, 5, 0);
    tick();       chk("lock.gap1.valid", out_valid, 0);
    sample(6);
    tick();       chk("lock.gap2.valid", out_valid, 0);
    sample(7);    chk("lock.s3.locked", locked, 0);
    tick();       chk("lock.gap3.locked", locked, 0);
    chk("lock.gap3.valid", out_valid, 0);
    sample(8);    chk_out("lock.s4", 1, 8, 0);
    chk("lock.s4.locked", locked, 1);
    tick();       chk("lock.hold", locked, 1);

    // 4: saturation, history all ones then driven to all zeros
    wr(0, -2000); wr(1, -2000); wr(2, -2000); wr(3, -2000);
    chk("sat.wr.locked", locked, 1);
    sample(32767);   chk_out("sat.hi", 1, 32767, 1);
    sample(-32768);  chk_out("sat.n1", 0, -24768, 0);
    sample(-32768);  chk_out("sat.n2", 0, -28768, 0);
    sample(-32768);  chk_out("sat.n3.edge", 0, -32768, 0);
    sample(-32768);  chk_out("sat.n4", 0, -32768, 1);
    sample(-32768);  chk_out("sat.lo", 0, -32768, 1);
    tick();
    chk("sat.idle.valid", out_valid, 0);
    chk("sat.idle.sat", sat_flag, 1);
    chk("sat.idle.eq", eq_out, -32768);
    sample(8000);    chk_out("sat.zero", 1, 0, 0);

    // 5: tap write on the same edge as a sample
    do_reset();
    sample(20);   chk_out("sim.pre", 1, 20, 0);
    tap_wr_en = 1'b1; tap_addr = 2'd0; tap_data = 12'sd100;
    din = 16'sd50; din_valid = 1'b1;
    tick();
    tap_wr_en = 1'b0; din_valid = 1'b0;
    chk_out("sim.same", 1, 50, 0);
    sample(50);   chk_out("sim.next", 0, -50, 0);

    // 6: reset while locked; the sample and write under reset are dropped
    sample(0);    chk_out("mid.lock", 1, 100, 0);
    chk("mid.locked", locked, 1);
    rst = 1'b1; din = 16'sd1234; din_valid = 1'b1;
    tap_wr_en = 1'b1; tap_addr = 2'd0; tap_data = 12'sd7;
    tick();
    rst = 1'b0; din_valid = 1'b0; tap_wr_en = 1'b0;
    chk("mid.rst.locked", locked, 0);
    chk("mid.rst.valid", out_valid, 0);
    chk("mid.rst.eq", eq_out, 0);
    chk("mid.rst.bit", out_bit, 0);
    sample(10);   chk_out("mid.s1", 1, 10, 0);
    chk("mid.s1.locked", locked, 0);
    sample(-3);   chk_out("mid.s2", 0, -3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_dfe.md
Name: rx_dfe

Overview:
Receive-side decision-feedback equalizer and slicer. It is the counterpart to the TX FFE.
- Input: the signed channel-filter output sample.
- Processing: subtracts a weighted sum of past decisions and slices the result to a bit.
- Output: the recovered bit stream, the equalized value and a lock indication for the downstream checker.
- Tap weights are programmed at runtime through a simple register write port.

Parameters:
- N_TAPS, 4, number of DFE feedback taps (≥1).
- SAMPLE_WIDTH, 16, width of signed input sample and equalized output.
- TAP_WIDTH, 12, width of signed tap weights.
- TAP_ADDR_WIDTH, 2, tap write address width, equal to clog2(N_TAPS), minimum 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- in, input, SAMPLE_WIDTH, signed filter output sample.
- in_valid, input, 1, in is valid this cycle.
- tap_wr_en, input, 1, write tap_data into tap tap_addr.
- tap_addr, input, TAP_ADDR_WIDTH, tap index (0 = most recent decision).
- tap_data, input, TAP_WIDTH, signed tap weight.
- out_bit, output, 1, sliced decision.
- out_valid, output, 1, out_bit/eq_out valid.
- eq_out, output, SAMPLE_WIDTH, signed equalized sample (saturated).
- sat_flag, output, 1, eq_out was saturated for this sample.
- locked, output, 1, history fully populated (RUN state).

Behaviour:
- Reset (rst=1 at posedge), values valid the following cycle:
  - out_bit=0, out_valid=0, eq_out=0, sat_flag=0, locked=0.
  - All tap weights cleared to 0; decision history cleared; fill counter 0; state FILL.
- Decision history: d[0..N_TAPS-1], where d[0] is the most recent decision. Shift occurs only on in_valid.
- Feedback: sum over active taps i of (d[i] ? +w[i] : −w[i]).
  - Tap i is active only when i < fill_count; inactive taps contribute 0.
- Arithmetic:
  - Internal width is SAMPLE_WIDTH+clog2(N_TAPS)+2, signed.
  - eq = in − feedback.
  - eq_out saturates to [−2^(SAMPLE_WIDTH−1), 2^(SAMPLE_WIDTH−1)−1]; sat_flag=1 iff clipping occurred.
- Slicer: decision = (eq ≥ 0). Zero maps to 1. The decision is taken on the unsaturated eq; sign is identical either way.
- Latency: one cycle. On a posedge with in_valid=1, out_bit/eq_out/sat_flag/out_valid are registered and visible that cycle; the new decision shifts into d[0] at the same edge.
- out_valid is a 1-cycle pulse per accepted sample. When in_valid=0, out_valid=0 and out_bit/eq_out/sat_flag hold their values.
- State machine:
  - FILL: fill_count increments per in_valid. Transition to RUN when the accepted sample brings fill_count to N_TAPS. locked=1 from the cycle after that edge.
  - RUN: fill_count saturates at N_TAPS; stays in RUN until rst.
- Tap writes:
  - A write takes effect at the posedge where tap_wr_en=1.
  - A sample accepted at the same edge uses the old weight.
  - tap_addr ≥ N_TAPS is ignored.
  - Writes are legal in any state and do not affect locked.
- Reset mid-operation: the cycle after rst, all state matches power-up. A sample presented with rst=1 is discarded.
- in_valid gaps do not advance history or fill_count.

Decomposition:
- rx_package (shared): RX_N_TAPS, RX_SAMPLE_WIDTH, RX_TAP_WIDTH, and the typedefs RX_SAMPLE_FORMAT (signed sample) and RX_TAP_FORMAT (signed tap). The sample format must match the filter-output format so rx_dfe can sit directly after the channel filter.
- Sub-module dfe_tap_sum: purely combinational. Inputs are decision history, weights and fill_count; output is the wide signed feedback. Keeps the adder tree separately testable.
- rx_dfe holds the registers, FSM, saturation and slicer.

Test Plan (N_TAPS=4, SAMPLE_WIDTH=16, TAP_WIDTH=12):
1. Reset → locked=0, out_valid=0, eq_out=0. Zero taps: samples +100, −1, 0 → out_bit 1,0,1; eq_out 100,−1,0, each one cycle after acceptance.
2. Masking: tap0=50, samples 100 then 30 → first uses no feedback (eq 100, bit 1); second eq=30−50=−20, bit 0.
3. Lock/gaps: 4 valid samples separated by idle cycles → locked rises the cycle after the 4th accepted edge, not before; idle cycles keep out_valid=0.
4. Saturation: all taps −2000, after lock with history all 1, in=32767 → eq_out=32767, sat_flag=1, out_bit=1. With in=−32768 and history all 0 (feedback +8000) → eq_out=−32768, sat_flag=1.
5. Simultaneous write: tap0 write 100 on the same edge as sample 50 with d[0]=1 and old tap0=0 → eq 50. The next sample, 50 with d[0]=1, gives eq −50.
6. Mid-run reset: rst for 1 cycle while locked with nonzero taps → next cycle locked=0, out_valid=0. The following sample 10 gives eq_out=10 (taps cleared, masked).
